// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_NOT   = 3'b101,
    OP_PASS  = 3'b110,
    OP_PASS2 = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub (wrapping), and/or/xor, not A, pass A.
// Latency: zero cycles, purely combinational.
// Backpressure: none; result follows operands.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] y
);

  // Opcode decode; both pass encodings return A unchanged.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one op in flight.
// Latency: accept in cycle c, response valid from cycle c+2; issue interval >= 3.
// Backpressure: response held stable until the owner's rsp ready; no accepts meanwhile.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  alu_op_t          req0_f,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  alu_op_t          req1_f,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             busy
);

  arb_state_t       state, next_state;
  logic             last_grant;
  logic             owner;
  logic [WIDTH-1:0] op_a, op_b, result;
  alu_op_t          op_f;
  logic [WIDTH-1:0] alu_y;
  logic             gnt0, gnt1, accept;

  // Requester 0 wins when alone or when requester 1 was served last, and vice versa.
  assign gnt0   = req0_valid & (~req1_valid | last_grant);
  assign gnt1   = req1_valid & (~req0_valid | ~last_grant);
  assign accept = (state == IDLE) & (gnt0 | gnt1);
  assign busy   = (state != IDLE);

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a  (op_a),
    .b  (op_b),
    .op (op_f),
    .y  (alu_y)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and handshake outputs; readies are masked while reset is held.
  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_data  = '0;
    rsp1_data  = '0;
    case (state)
      IDLE: begin
        req0_ready = gnt0 & rst_n;
        req1_ready = gnt1 & rst_n;
        if (gnt0 | gnt1) next_state = EXEC;
      end
      EXEC: next_state = RESP;
      RESP: begin
        if (!owner) begin
          rsp0_valid = 1'b1;
          rsp0_data  = result;
          if (rsp0_ready) next_state = IDLE;
        end else begin
          rsp1_valid = 1'b1;
          rsp1_data  = result;
          if (rsp1_ready) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture on accept, result capture in the single EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_f       <= OP_ADD;
      result     <= '0;
    end else begin
      if (accept) begin
        owner      <= gnt1;
        last_grant <= gnt1;
        op_a       <= gnt1 ? req1_a : req0_a;
        op_b       <= gnt1 ? req1_b : req0_b;
        op_f       <= gnt1 ? req1_f : req0_f;
      end
      if (state == EXEC) result <= alu_y;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arbitration order, latency, hold, reset and opcodes.
// Latency: checks response exactly two cycles after the ready cycle.
// Backpressure: exercises held rsp ready and non-owner ready.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  alu_op_t     req0_f, req1_f;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp0_data, rsp1_data;
  logic        busy;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp8 [8] = '{16'h1333, 16'h1135, 16'h0034, 16'h12FF,
                            16'h12CB, 16'hEDCB, 16'h1234, 16'h1234};

  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation on requester n, checking ready, latency and handshake.
  task automatic run_op(input int n, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] f, input logic [15:0] exp, input string tag);
    if (n == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = alu_op_t'(f);
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = alu_op_t'(f);
    end
    #1;
    chk({tag, "_rdy"}, (n == 0) ? req0_ready : req1_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    tick();
    chk({tag, "_vld"}, (n == 0) ? rsp0_valid : rsp1_valid, 1);
    chk({tag, "_dat"}, (n == 0) ? rsp0_data : rsp1_data, exp);
    if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0004; req0_f = OP_ADD;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_f = OP_ADD;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #12;
    // Reset state with both requests asserted.
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vld", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_dat", {rsp0_data, rsp1_data}, 0);
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single add from requester 0, exact latency.
    #1;
    chk("t33_rdy0", req0_ready, 1);
    chk("t33_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("t33_exec_vld", rsp0_valid, 0);
    chk("t33_exec_rdy", req0_ready, 0);
    tick();
    chk("t33_vld", rsp0_valid, 1);
    chk("t33_dat", rsp0_data, 16'h0007);
    chk("t33_other", {rsp1_valid, rsp1_data}, 0);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chk("t33_done", {busy, rsp0_valid, rsp0_data}, 0);

    // Tie from reset: requester 0 first, then requester 1.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0001; req0_f = OP_ADD;
    req1_valid = 1'b1; req1_a = 16'h00F0; req1_b = 16'h0F0F; req1_f = OP_XOR;
    #1;
    chk("t34_rdy", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 1'b0;
    chk("t34_exec_rdy1", req1_ready, 0);
    tick();
    chk("t34_dat0", {rsp0_valid, rsp0_data}, {1'b1, 16'h0000});
    chk("t34_resp_rdy1", req1_ready, 0);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chk("t34_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("t34_dat1", {rsp1_valid, rsp1_data}, {1'b1, 16'h0FFF});
    chk("t34_vld0", rsp0_valid, 0);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;

    // Both held valid: strict alternation over six operations.
    req0_valid = 1'b1; req0_a = 16'h0A0A; req0_f = OP_PASS;
    req1_valid = 1'b1; req1_a = 16'h0B0B; req1_f = OP_PASS2;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("t35_gnt", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      tick();
      chk("t35_rsp", {rsp0_valid, rsp1_valid}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("t35_dat", (i % 2 == 0) ? rsp0_data : rsp1_data, (i % 2 == 0) ? 16'h0A0A : 16'h0B0B);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();

    // Held response on requester 1 blocks requester 0; non-owner ready ignored.
    req1_valid = 1'b1; req1_a = 16'h0000; req1_b = 16'h0001; req1_f = OP_SUB;
    #1;
    chk("t36_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_f = OP_ADD;
    rsp0_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t36_hold", {rsp1_valid, rsp1_data}, {1'b1, 16'hFFFF});
      chk("t36_block", {req0_ready, rsp0_valid, busy}, 3'b001);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    chk("t36_hs_rdy0", req0_ready, 0);
    tick();
    rsp1_ready = 1'b0;
    chk("t36_after", {rsp1_valid, req0_ready}, 2'b01);
    tick();
    req0_valid = 1'b0;
    tick();
    chk("t36_dat0", {rsp0_valid, rsp0_data}, {1'b1, 16'h0002});
    tick();
    rsp0_ready = 1'b0;
    chk("t36_idle", busy, 0);

    // Reset during EXEC discards the operation.
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0000; req0_f = OP_NOT;
    #1;
    chk("t37_rdy0", req0_ready, 1);
    tick();
    chk("t37_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t37_rst", {busy, rsp0_valid, req0_ready, rsp0_data}, 0);
    req0_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t37_norsp", {rsp0_valid, rsp1_valid, busy}, 0);
      tick();
    end
    run_op(1, 16'h0005, 16'h0006, 3'b000, 16'h000B, "t37_next");

    // Every opcode with A=0x1234 B=0x00FF.
    for (int i = 0; i < 8; i++) begin
      run_op(0, 16'h1234, 16'h00FF, 3'(i), exp8[i], "t38_op");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  in  WIDTH  requester 0 operands A, B.
REQ-007 req0_f  in  3  requester 0 opcode (alu_op_t).
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_f: same as REQ-004..007, for requester 1.
REQ-009 rsp0_valid  out  1  result for requester 0 available.
REQ-010 rsp0_ready  in  1  requester 0 consumes result.
REQ-011 rsp0_data  out  WIDTH  requester 0 result.
REQ-012 rsp1_valid, rsp1_ready, rsp1_data: same as REQ-009..011, for requester 1.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 Opcodes: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 and 111 pass A.
REQ-015 Add/sub wrap modulo 2^WIDTH; no carry or overflow output.
REQ-016 FSM states: IDLE, EXEC, RESP; exactly one operation in flight.
REQ-017 IDLE: grant = 0 if req0_valid and (not req1_valid or last_grant=1); grant = 1 if req1_valid and (not req0_valid or last_grant=0).
REQ-018 IDLE: reqN_ready = 1 for the granted N only, combinational; both ready low when neither valid; readies are 0 in EXEC and RESP.
REQ-019 Accept (IDLE, reqN_valid & reqN_ready): latch A, B, F and owner=N; last_grant<=N; next state EXEC.
REQ-020 EXEC: ALU result of latched operands registered into result register; next state RESP (always exactly one cycle).
REQ-021 RESP: rspN_valid=1 for owner only, rspN_data=result; the other rsp_valid is 0.
REQ-022 RESP: stay while rsp_ready of owner is 0; result and valid held stable.
REQ-023 RESP with owner's rsp_ready=1: next state IDLE; a new request is not accepted in the same cycle.
REQ-024 Latency: accept at edge k, rsp valid from cycle k+2; minimum issue interval 3 cycles.
REQ-025 rsp_data of non-owner and all rsp_data outside RESP = 0.
REQ-026 Requester valid may drop before acceptance without effect; requester inputs ignored outside IDLE.
REQ-027 Rsp_ready of non-owner is ignored.

Reset
REQ-028 Reset low: state=IDLE, last_grant=1 (requester 0 wins first tie), owner=0, latched operands/opcode/result=0, immediately and independent of Clk.
REQ-029 Reset low: all ready/valid/busy outputs 0, rsp data 0.
REQ-030 Reset mid-operation: in-flight operation discarded; no response issued after reset release.

Structure
REQ-031 Package alu_pkg: alu_op_t (3-bit enum, REQ-014 codes), arb_state_t (IDLE/EXEC/RESP), WIDTH default constant.
REQ-032 One sub-module: alu_core (combinational, WIDTH operands, alu_op_t select), instantiated once, fed from latched registers.

Verification
REQ-033 After reset, req0 valid A=0x0003 B=0x0004 F=000 -> req0_ready same cycle, rsp0_valid 2 cycles later, rsp0_data=0x0007.
REQ-034 Both valid from reset: req0 A=0xFFFF B=0x0001 F=000, req1 A=0x00F0 B=0x0F0F F=100 -> req0 served first (0x0000), then req1 (0x0FFF).
REQ-035 Both requesters held continuously valid for 6 ops -> grants alternate 0,1,0,1,0,1; no starvation.
REQ-036 req1 F=001 A=0x0000 B=0x0001, rsp1_ready held 0 for 5 cycles -> rsp1_valid stays 1, data 0xFFFF stable, req0 not accepted until handshake.
REQ-037 Reset asserted in EXEC of req0 op F=101 A=0x00FF -> outputs 0 immediately; after release no rsp0_valid; next req accepted normally.
REQ-038 Each opcode 000-111 with A=0x1234 B=0x00FF -> 0x1333, 0x1135, 0x0034, 0x12FF, 0x12CB, 0xEDCB, 0x1234, 0x1234.
